nonce_arbiter: RTL
==================

Name: nonce_arbiter

Overview:
- Shares one nonce_generator between NUM_CLIENTS requesters using round-robin arbitration.
- Sequences the generator's single-cycle req / valid handshake and captures the 64-bit nonce.
- Returns the nonce to the granted client with a one-cycle ack, or an error on timeout.
- Sits between the protocol engines and the nonce_generator instance.

Parameters:
- NUM_CLIENTS, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, max cycles waiting for gen_valid after gen_req (≥2).
- NONCE_W, 64, nonce width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cli_req  in  NUM_CLIENTS  level request per client; held until that client's ack or err.
- cli_ack  out  NUM_CLIENTS  one-cycle pulse: cli_nonce valid for that client.
- cli_err  out  NUM_CLIENTS  one-cycle pulse: request failed (timeout or duplicate).
- cli_nonce  out  NONCE_W  shared nonce bus; holds last captured value.
- busy  out  1  high in any state other than IDLE.
- gen_req  out  1  one-cycle request pulse to nonce_generator.
- gen_valid  in  1  nonce_generator result valid.
- gen_nonce  in  NONCE_W  nonce_generator result.

Behaviour:
- Reset, asynchronous: state=IDLE, rr_ptr=0, grant=0, timeout counter=0; all outputs 0, including cli_nonce.
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE:
  - If any cli_req is set, pick the first set bit searching from rr_ptr upward with wrap-around.
  - Register it as grant and go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - gen_req=1 for exactly this one cycle.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - On the first cycle gen_valid=1, capture gen_nonce into cli_nonce and go to DELIVER.
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT_CYCLES-1 with no valid, pulse cli_err[grant] and go to IDLE.
  - gen_valid in any state other than WAIT is ignored.
- DELIVER:
  - Pulse cli_ack[grant] if cli_req[grant] is still high; otherwise discard the nonce with no ack.
  - Set rr_ptr=(grant+1) mod NUM_CLIENTS; go to IDLE.
- rr_ptr also advances the same way after a timeout error.
- Latency: a request sampled in IDLE at cycle T drives gen_req at T+1. Ack comes 1 cycle after the captured valid. Best case is gen_valid at T+2 and ack at T+3.
- At most one transaction is in flight. Other requests wait; they are never dropped.
- A client dropping cli_req mid-transaction does not abort it. The generator handshake always completes.
- Simultaneous requests: strict round-robin. No client gets two consecutive grants while another client is requesting.
- cli_ack and cli_err are never both high, and at most one bit of either is set.
- Reset mid-transaction returns to IDLE immediately with gen_req=0. A late gen_valid after reset is ignored.

Optional Feature:
- Macro: NONCE_DUP_CHECK_EN.
- With the macro defined:
  - Keep the last delivered nonce plus a have_last flag, cleared on reset.
  - In WAIT, if have_last=1 and gen_nonce equals the last nonce, do not deliver. Return to ISSUE once (retry).
  - A second consecutive duplicate in the same transaction pulses cli_err[grant] and goes to IDLE.
  - A successful DELIVER updates the last nonce.
- Without the macro: no comparison and no retry; every captured nonce is delivered.

Decomposition:
- Package nonce_pkg holds:
  - the FSM state enum type;
  - NONCE_W_DEF=64;
  - the client index type, width $clog2(NUM_CLIENTS).
- Sub-module rr_arbiter: combinational round-robin picker. Inputs are the request vector and rr_ptr; outputs are grant index and any_req.
- FSM, timeout counter and capture register live in nonce_arbiter.

Test Plan:
- Single request: cli_req=4'b0010 with a generator answering in 1 cycle -> gen_req pulses once, then cli_ack=4'b0010 for one cycle, cli_nonce equals gen_nonce, busy drops.
- Contention: cli_req=4'b1111 held -> grants in order 0,1,2,3,0; exactly one gen_req per ack; the nonces received are distinct.
- Timeout: generator never asserts valid with TIMEOUT_CYCLES=16 -> cli_err[grant] pulses 16 cycles after gen_req; the next client is served afterwards.
- Withdrawn request: client 2 drops cli_req during WAIT -> no ack to client 2; FSM returns to IDLE; rr_ptr=3.
- Reset mid-WAIT: assert rst for 2 cycles, then a stray gen_valid arrives -> all outputs 0; no ack; the next request is handled normally.
- NONCE_DUP_CHECK_EN: the generator repeats 64'h0123_4567_89AB_CDEF twice -> second gen_req issued. A third repeat -> cli_err pulses; a fresh value -> cli_ack.

Source files
------------

// File: rtl/nonce_pkg.sv
// Shared types and defaults for the nonce arbiter slice.
// Duplicate-nonce rejection is enabled with the NONCE_DUP_CHECK_EN macro.
package nonce_pkg;

    localparam int NONCE_W_DEF     = 64;
    localparam int NUM_CLIENTS_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_e;

    typedef logic [$clog2(NUM_CLIENTS_DEF)-1:0] client_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap-around.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant,
    output logic             any_req
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int off = 0; off < N; off++) begin
            idx = IDX_W'((int'(ptr) + off) % N);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                grant   = idx;
            end
        end
    end

endmodule

// File: rtl/nonce_arbiter.sv
// Round-robin sharing of one nonce_generator among NUM_CLIENTS requesters.
// Define NONCE_DUP_CHECK_EN to reject a nonce equal to the last delivered one (one retry).
module nonce_arbiter
    import nonce_pkg::*;
#(
    parameter int NUM_CLIENTS    = NUM_CLIENTS_DEF,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int NONCE_W        = NONCE_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CLIENTS-1:0] cli_req,
    output logic [NUM_CLIENTS-1:0] cli_ack,
    output logic [NUM_CLIENTS-1:0] cli_err,
    output logic [NONCE_W-1:0]     cli_nonce,
    output logic                   busy,
    output logic                   gen_req,
    input  logic                   gen_valid,
    input  logic [NONCE_W-1:0]     gen_nonce,
    output logic [1:0]             dbg_state
);

    // Handshakes: cli_req is a level held by the client until its one-cycle
    // cli_ack/cli_err; gen_req is a one-cycle strobe with no ready, answered by
    // a single gen_valid cycle that is only honoured while in WAIT.

    localparam int IDX_W = $clog2(NUM_CLIENTS);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CLIENTS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
`ifdef NONCE_DUP_CHECK_EN
    logic [NONCE_W-1:0] last_q, last_d;
    logic               have_last_q, have_last_d;
    logic               retry_q, retry_d;
`endif

    logic [IDX_W-1:0] pick_idx;
    logic             any_req;
    logic [IDX_W-1:0] next_ptr;
    logic             fail;

    rr_arbiter #(
        .N     (NUM_CLIENTS),
        .IDX_W (IDX_W)
    ) u_rr (
        .req     (cli_req),
        .ptr     (rr_ptr_q),
        .grant   (pick_idx),
        .any_req (any_req)
    );

    assign next_ptr  = (grant_q == IDX_LAST) ? '0 : grant_q + 1'b1;
    assign cli_nonce = nonce_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        nonce_d  = nonce_q;
`ifdef NONCE_DUP_CHECK_EN
        last_d      = last_q;
        have_last_d = have_last_q;
        retry_d     = retry_q;
`endif
        fail    = 1'b0;
        gen_req = 1'b0;
        cli_ack = '0;
        cli_err = '0;
        busy    = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d = pick_idx;
                    state_d = ST_ISSUE;
`ifdef NONCE_DUP_CHECK_EN
                    retry_d = 1'b0;
`endif
                end
            end
            ST_ISSUE: begin
                gen_req = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (gen_valid) begin
`ifdef NONCE_DUP_CHECK_EN
                    if (have_last_q && (gen_nonce == last_q)) begin
                        if (retry_q) begin
                            fail = 1'b1;
                        end else begin
                            retry_d = 1'b1;
                            state_d = ST_ISSUE;
                        end
                    end else begin
                        nonce_d = gen_nonce;
                        state_d = ST_DELIVER;
                    end
`else
                    nonce_d = gen_nonce;
                    state_d = ST_DELIVER;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DELIVER: begin
                // A client that withdrew mid-transaction simply loses this nonce.
                if (cli_req[grant_q]) begin
                    cli_ack[grant_q] = 1'b1;
`ifdef NONCE_DUP_CHECK_EN
                    last_d      = nonce_q;
                    have_last_d = 1'b1;
`endif
                end
                rr_ptr_d = next_ptr;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (fail) begin
            cli_err[grant_q] = 1'b1;
            rr_ptr_d         = next_ptr;
            state_d          = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            nonce_q  <= '0;
`ifdef NONCE_DUP_CHECK_EN
            last_q      <= '0;
            have_last_q <= 1'b0;
            retry_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            nonce_q  <= nonce_d;
`ifdef NONCE_DUP_CHECK_EN
            last_q      <= last_d;
            have_last_q <= have_last_d;
            retry_q     <= retry_d;
`endif
        end
    end

endmodule
